// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller signal bundle: ID/EX hazard inputs, memory handshake status,
// and the stall/flush/hold controls plus statistics returned to the pipeline.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs_addr;
    logic [4:0]       id_rt_addr;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic             ex_mem_r;
    logic [4:0]       ex_dst_addr;
    logic             id_branch_taken;
    // mem_req/mem_ready: an access in MEM completes on any cycle where both are high;
    // mem_req high with mem_ready low is a wait state.
    logic             mem_req;
    logic             mem_ready;
    logic             pc_we;
    logic             if_id_we;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             pipe_hold;
    logic             mem_err;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport slave (
        input  id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt,
        input  ex_mem_r, ex_dst_addr, id_branch_taken, mem_req, mem_ready,
        output pc_we, if_id_we, if_id_flush, id_ex_bubble, pipe_hold,
        output mem_err, state, stall_cnt, flush_cnt
    );

    modport master (
        output id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt,
        output ex_mem_r, ex_dst_addr, id_branch_taken, mem_req, mem_ready,
        input  pc_we, if_id_we, if_id_flush, id_ex_bubble, pipe_hold,
        input  mem_err, state, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use bubbles, taken-branch
// flushes, data-memory wait holds with timeout trap, and saturating statistics.
module pipe_hazard_ctrl #(
    parameter int CNT_W    = 16,
    parameter int MAX_WAIT = 8
) (
    input logic               clk,
    input logic               rst_n,
    pipe_hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_e;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_e           state_q, state_d;
    logic [7:0]       wait_q, wait_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    logic lu;
    logic mw;
    logic apply_run;
    logic pc_we_s, if_id_we_s, flush_s, bubble_s, hold_s;

    assign lu = hz.ex_mem_r && (hz.ex_dst_addr != 5'd0) &&
                ((hz.id_uses_rs && (hz.id_rs_addr == hz.ex_dst_addr)) ||
                 (hz.id_uses_rt && (hz.id_rt_addr == hz.ex_dst_addr)));
    assign mw = hz.mem_req && !hz.mem_ready;

    always_comb begin
        pc_we_s    = 1'b1;
        if_id_we_s = 1'b1;
        flush_s    = 1'b0;
        bubble_s   = 1'b0;
        hold_s     = 1'b0;
        apply_run  = 1'b0;
        state_d    = state_q;
        wait_d     = wait_q;

        case (state_q)
            RUN: begin
                if (mw) begin
                    pc_we_s    = 1'b0;
                    if_id_we_s = 1'b0;
                    hold_s     = 1'b1;
                    state_d    = MEM_WAIT;
                    wait_d     = 8'd0;
                end else begin
                    apply_run = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (!hz.mem_ready) begin
                    pc_we_s    = 1'b0;
                    if_id_we_s = 1'b0;
                    hold_s     = 1'b1;
                    if (wait_q == WAIT_LAST) state_d = ERR;
                    else                     wait_d  = wait_q + 8'd1;
                end else begin
                    // Completion on the last allowed cycle still beats the timeout.
                    apply_run = 1'b1;
                    state_d   = RUN;
                end
            end
            ERR: begin
                pc_we_s    = 1'b0;
                if_id_we_s = 1'b0;
                hold_s     = 1'b1;
            end
            default: state_d = RUN;
        endcase

        // A taken branch seen during a load-use stall is re-evaluated next cycle.
        if (apply_run) begin
            if (lu) begin
                pc_we_s    = 1'b0;
                if_id_we_s = 1'b0;
                bubble_s   = 1'b1;
            end else if (hz.id_branch_taken) begin
                flush_s = 1'b1;
            end
        end

        // Reset loads NOPs into IF/ID and ID/EX while the pipeline is frozen.
        if (!rst_n) begin
            pc_we_s    = 1'b0;
            if_id_we_s = 1'b0;
            flush_s    = 1'b1;
            bubble_s   = 1'b1;
            hold_s     = 1'b0;
        end
    end

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (!pc_we_s && (stall_q != {CNT_W{1'b1}})) stall_d = stall_q + 1'b1;
        if (flush_s && (flush_q != {CNT_W{1'b1}}))  flush_d = flush_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            wait_q  <= 8'd0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign hz.pc_we        = pc_we_s;
    assign hz.if_id_we     = if_id_we_s;
    assign hz.if_id_flush  = flush_s;
    assign hz.id_ex_bubble = bubble_s;
    assign hz.pipe_hold    = hold_s;
    assign hz.mem_err      = (state_q == ERR);
    assign hz.state        = state_q;
    assign hz.stall_cnt    = stall_q;
    assign hz.flush_cnt    = flush_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: three instances cover the default build,
// a short timeout (MAX_WAIT=4) and narrow saturating counters (CNT_W=4).
module tb_pipe_hazard_ctrl;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    pipe_hazard_ctrl_if #(.CNT_W(16)) if_a ();
    pipe_hazard_ctrl_if #(.CNT_W(16)) if_b ();
    pipe_hazard_ctrl_if #(.CNT_W(4))  if_c ();

    pipe_hazard_ctrl #(.CNT_W(16), .MAX_WAIT(8)) dut_a (.clk(clk), .rst_n(rst_n), .hz(if_a));
    pipe_hazard_ctrl #(.CNT_W(16), .MAX_WAIT(4)) dut_b (.clk(clk), .rst_n(rst_n), .hz(if_b));
    pipe_hazard_ctrl #(.CNT_W(4),  .MAX_WAIT(8)) dut_c (.clk(clk), .rst_n(rst_n), .hz(if_c));

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Checker
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drivers: inputs change 1 ns after the rising edge, outputs are sampled 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic mem_r, input logic [4:0] dst,
                           input logic urs, input logic [4:0] rs,
                           input logic urt, input logic [4:0] rt,
                           input logic br, input logic req, input logic rdy);
        if_a.ex_mem_r        = mem_r;
        if_a.ex_dst_addr     = dst;
        if_a.id_uses_rs      = urs;
        if_a.id_rs_addr      = rs;
        if_a.id_uses_rt      = urt;
        if_a.id_rt_addr      = rt;
        if_a.id_branch_taken = br;
        if_a.mem_req         = req;
        if_a.mem_ready       = rdy;
        #1;
    endtask

    task automatic drive_b(input logic req, input logic rdy);
        if_b.mem_req   = req;
        if_b.mem_ready = rdy;
        #1;
    endtask

    task automatic drive_c_lu(input logic on);
        if_c.ex_mem_r    = on;
        if_c.ex_dst_addr = 5'd3;
        if_c.id_uses_rs  = on;
        if_c.id_rs_addr  = 5'd3;
        #1;
    endtask

    initial begin
        int exp_stall;
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        {if_b.id_rs_addr, if_b.id_rt_addr, if_b.ex_dst_addr} = '0;
        {if_b.id_uses_rs, if_b.id_uses_rt, if_b.ex_mem_r, if_b.id_branch_taken} = '0;
        {if_c.id_rt_addr, if_c.id_uses_rt, if_c.id_branch_taken} = '0;
        {if_c.mem_req, if_c.mem_ready} = '0;
        drive_b(1'b0, 1'b0);
        drive_c_lu(1'b0);
        drive_a(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0);

        // Reset behaviour
        check_eq("rst_pc_we", if_a.pc_we, 0);
        check_eq("rst_if_id_we", if_a.if_id_we, 0);
        check_eq("rst_flush", if_a.if_id_flush, 1);
        check_eq("rst_bubble", if_a.id_ex_bubble, 1);
        check_eq("rst_hold", if_a.pipe_hold, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check_eq("post_rst_pc_we", if_a.pc_we, 1);
        check_eq("post_rst_flush", if_a.if_id_flush, 0);
        check_eq("post_rst_state", if_a.state, 0);
        check_eq("post_rst_stall_cnt", if_a.stall_cnt, 0);
        check_eq("post_rst_flush_cnt", if_a.flush_cnt, 0);
        check_eq("post_rst_mem_err", if_a.mem_err, 0);

        // Load-use on Rt
        step();
        drive_a(1, 5'd8, 0, 5'd0, 1, 5'd8, 0, 0, 0);
        check_eq("lu_rt_pc_we", if_a.pc_we, 0);
        check_eq("lu_rt_if_id_we", if_a.if_id_we, 0);
        check_eq("lu_rt_bubble", if_a.id_ex_bubble, 1);
        check_eq("lu_rt_hold", if_a.pipe_hold, 0);
        step();
        drive_a(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0);
        check_eq("lu_after_pc_we", if_a.pc_we, 1);
        check_eq("lu_after_stall_cnt", if_a.stall_cnt, 1);

        // Destination r0 never stalls
        drive_a(1, 5'd0, 0, 5'd0, 1, 5'd0, 0, 0, 0);
        check_eq("lu_r0_pc_we", if_a.pc_we, 1);
        check_eq("lu_r0_bubble", if_a.id_ex_bubble, 0);
        step();

        // Load-use on Rs; then matching Rs that is not read
        drive_a(1, 5'd5, 1, 5'd5, 0, 5'd0, 0, 0, 0);
        check_eq("lu_rs_pc_we", if_a.pc_we, 0);
        check_eq("lu_rs_bubble", if_a.id_ex_bubble, 1);
        step();
        drive_a(1, 5'd5, 0, 5'd5, 1, 5'd6, 0, 0, 0);
        check_eq("lu_unused_pc_we", if_a.pc_we, 1);
        check_eq("lu_unused_stall_cnt", if_a.stall_cnt, 2);
        step();

        // Load-use beats a taken branch; branch acts next cycle
        drive_a(1, 5'd9, 0, 5'd0, 1, 5'd9, 1, 0, 0);
        check_eq("lubr_bubble", if_a.id_ex_bubble, 1);
        check_eq("lubr_flush", if_a.if_id_flush, 0);
        check_eq("lubr_pc_we", if_a.pc_we, 0);
        step();
        drive_a(0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 0);
        check_eq("br_flush", if_a.if_id_flush, 1);
        check_eq("br_pc_we", if_a.pc_we, 1);
        check_eq("br_if_id_we", if_a.if_id_we, 1);
        step();
        drive_a(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0);
        check_eq("br_flush_cnt", if_a.flush_cnt, 1);
        check_eq("br_stall_cnt", if_a.stall_cnt, 3);

        // Memory wait: 3 held cycles, then completion
        for (int i = 0; i < 3; i++) begin
            if (i > 0) step();
            drive_a(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0);
            check_eq("mw_hold", if_a.pipe_hold, 1);
            check_eq("mw_pc_we", if_a.pc_we, 0);
            check_eq("mw_bubble", if_a.id_ex_bubble, 0);
            check_eq("mw_state", if_a.state, (i == 0) ? 0 : 1);
        end
        step();
        drive_a(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 1);
        check_eq("mw_done_hold", if_a.pipe_hold, 0);
        check_eq("mw_done_pc_we", if_a.pc_we, 1);
        check_eq("mw_done_state", if_a.state, 1);
        step();
        drive_a(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0);
        check_eq("mw_back_state", if_a.state, 0);
        check_eq("mw_stall_cnt", if_a.stall_cnt, 6);

        // Memory wait beats load-use; load-use applies when memory completes
        drive_a(1, 5'd4, 1, 5'd4, 0, 5'd0, 0, 1, 0);
        check_eq("mwlu_hold", if_a.pipe_hold, 1);
        check_eq("mwlu_bubble", if_a.id_ex_bubble, 0);
        step();
        drive_a(1, 5'd4, 1, 5'd4, 0, 5'd0, 0, 1, 1);
        check_eq("mwlu_done_hold", if_a.pipe_hold, 0);
        check_eq("mwlu_done_bubble", if_a.id_ex_bubble, 1);
        check_eq("mwlu_done_pc_we", if_a.pc_we, 0);
        step();
        drive_a(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0);
        check_eq("mwlu_state", if_a.state, 0);
        check_eq("mwlu_stall_cnt", if_a.stall_cnt, 8);

        // MAX_WAIT=4: completion on the last allowed cycle wins over timeout
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            drive_b(1, 0);
        end
        step();
        drive_b(1, 1);
        check_eq("tmo_edge_state", if_b.state, 1);
        check_eq("tmo_edge_pc_we", if_b.pc_we, 1);
        step();
        drive_b(0, 0);
        check_eq("tmo_edge_back_state", if_b.state, 0);
        check_eq("tmo_edge_mem_err", if_b.mem_err, 0);

        // MAX_WAIT=4: five stalled cycles, then ERR
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step();
            drive_b(1, 0);
            check_eq("tmo_pc_we", if_b.pc_we, 0);
            check_eq("tmo_no_err", if_b.mem_err, 0);
        end
        step();
        check_eq("tmo_state_err", if_b.state, 2);
        check_eq("tmo_mem_err", if_b.mem_err, 1);
        drive_b(1, 1);
        check_eq("err_ready_pc_we", if_b.pc_we, 0);
        check_eq("err_ready_hold", if_b.pipe_hold, 1);
        step();
        drive_b(0, 0);
        check_eq("err_sticky_state", if_b.state, 2);
        check_eq("err_sticky_mem_err", if_b.mem_err, 1);
        rst_n = 1'b0;
        #1;
        check_eq("err_rst_mem_err", if_b.mem_err, 0);
        check_eq("err_rst_state", if_b.state, 0);
        check_eq("err_rst_stall_cnt", if_b.stall_cnt, 0);
        step();
        rst_n = 1'b1;
        #1;
        check_eq("err_rel_pc_we", if_b.pc_we, 1);

        // CNT_W=4: stall counter saturates at 15
        exp_stall = 0;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) step();
            drive_c_lu(1'b1);
            check_eq("sat_pc_we", if_c.pc_we, 0);
            check_eq("sat_stall_cnt", if_c.stall_cnt, exp_stall);
            if (exp_stall < 15) exp_stall++;
        end
        step();
        drive_c_lu(1'b0);
        check_eq("sat_final_stall_cnt", if_c.stall_cnt, 15);
        step();
        check_eq("sat_hold_stall_cnt", if_c.stall_cnt, 15);

        // Report
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
